// File: rtl/reg_file_8x8_if.sv
// Operand/result bus between decode/ALU and the 8x8 register file.
// The master drives addresses, write data and strobes; the slave returns registered read data.
interface reg_file_8x8_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic [WIDTH-1:0]  IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic              READ;
  logic [WIDTH-1:0]  OUT1;
  logic [WIDTH-1:0]  OUT2;
  logic              VALID;
  logic [7:0]        WRCOUNT;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, READ,
    input  OUT1, OUT2, VALID, WRCOUNT
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, READ,
    output OUT1, OUT2, VALID, WRCOUNT
  );
endinterface

// File: rtl/reg_file_8x8.sv
// 8-entry register file with two registered read ports, one write port,
// optional write-to-read forwarding and a wrapping count of accepted writes.
module reg_file_8x8 #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  reg_file_8x8_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0]            out1_q, out1_d;
  logic [WIDTH-1:0]            out2_q, out2_d;
  logic                        valid_q, valid_d;
  logic [7:0]                  wrcnt_q, wrcnt_d;

  // Read sees the pre-write contents unless forwarding is enabled and the
  // same address is being written on this edge.
  function automatic logic [WIDTH-1:0] rd_data(input logic [ADDR_W-1:0] a);
    if ((BYPASS != 0) && bus.WRITE && (a == bus.INADDRESS)) return bus.IN;
    return mem_q[a];
  endfunction

  always_comb begin
    mem_d   = mem_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    wrcnt_d = wrcnt_q;
    valid_d = bus.READ;
    if (bus.READ) begin
      out1_d = rd_data(bus.OUT1ADDRESS);
      out2_d = rd_data(bus.OUT2ADDRESS);
    end
    if (bus.WRITE) begin
      mem_d[bus.INADDRESS] = bus.IN;
      wrcnt_d              = wrcnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      valid_q <= 1'b0;
      wrcnt_q <= '0;
    end else begin
      mem_q   <= mem_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      valid_q <= valid_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  assign bus.OUT1    = out1_q;
  assign bus.OUT2    = out2_q;
  assign bus.VALID   = valid_q;
  assign bus.WRCOUNT = wrcnt_q;

endmodule
